// File: rtl/pingpong_framebuffer_if.sv
// Bus bundle between the control writer, the video reader and the ping-pong
// framebuffer. Signal names keep the I_/O_ direction prefixes as seen from
// the framebuffer.
interface pingpong_framebuffer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              I_wr_en;
   logic [ADDR_W-1:0] I_wr_addr;
   logic [DATA_W-1:0] I_wr_data;
   logic              O_wr_ready;
   logic              I_swap_req;
   logic              O_swap_pending;
   logic              O_swap_done;
   logic              I_frame_start;
   logic              I_rd_en;
   logic [ADDR_W-1:0] I_rd_addr;
   logic [DATA_W-1:0] O_rd_data;
   logic              O_rd_valid;
   logic              O_front_bank;

   // Control/video side.
   modport master (
      output I_wr_en, I_wr_addr, I_wr_data, I_swap_req, I_frame_start,
             I_rd_en, I_rd_addr,
      input  O_wr_ready, O_swap_pending, O_swap_done, O_rd_data,
             O_rd_valid, O_front_bank
   );

   // Framebuffer side.
   modport slave (
      input  I_wr_en, I_wr_addr, I_wr_data, I_swap_req, I_frame_start,
             I_rd_en, I_rd_addr,
      output O_wr_ready, O_swap_pending, O_swap_done, O_rd_data,
             O_rd_valid, O_front_bank
   );
endinterface

// File: rtl/pingpong_framebuffer.sv
// Double-buffered pixel memory. The writer always targets the back bank, the
// video reader always reads the front bank. A swap request is armed and only
// committed on the next frame boundary; optionally the new back bank is then
// filled with CLEAR_VALUE while writes are refused.
module pingpong_framebuffer #(
   parameter int              DATA_W        = 8,
   parameter int              ADDR_W        = 4,
   parameter bit              CLEAR_ON_SWAP = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input  logic                    I_clk,
   input  logic                    I_rst,
   pingpong_framebuffer_if.slave   bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      CLEAR   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                front_q, front_d;
   logic                swap_done_q, swap_done_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;

   // Both banks live in one array; the bank index is the address MSB.
   logic [DATA_W-1:0]   mem [0:2*DEPTH-1];

   logic                mem_we;
   logic [ADDR_W:0]     mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   // Next-state logic: arm on request, commit on frame start, then clear.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d     = state_q;
      front_d     = front_q;
      swap_done_d = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            // A frame start in the same cycle as the request only arms.
            if (bus.I_swap_req) state_d = PENDING;
         end
         PENDING: begin
            if (bus.I_frame_start) begin
               front_d     = ~front_q;
               swap_done_d = 1'b1;
               cnt_d       = '0;
               state_d     = CLEAR_ON_SWAP ? CLEAR : IDLE;
            end
         end
         CLEAR: begin
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Single write port: the clear sweep owns it, otherwise the writer does.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = {~front_q, bus.I_wr_addr};
      mem_wdata = bus.I_wr_data;
      if (state_q == CLEAR) begin
         mem_we    = ~I_rst;
         mem_waddr = {~front_q, cnt_q};
         mem_wdata = CLEAR_VALUE;
      end else begin
         mem_we    = bus.I_wr_en & ~I_rst;
      end
   end

   // Control registers and the registered read port.
   always_ff @(posedge I_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (I_rst) begin
         state_q     <= IDLE;
         front_q     <= 1'b0;
         swap_done_q <= 1'b0;
         cnt_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         front_q     <= front_d;
         swap_done_q <= swap_done_d;
         cnt_q       <= cnt_d;
         rd_valid_q  <= bus.I_rd_en;
         // Uses the pre-commit front bank on the swap cycle.
         if (bus.I_rd_en) rd_data_q <= mem[{front_q, bus.I_rd_addr}];
      end
   end

   // Pixel storage write.
   always_ff @(posedge I_clk) begin
      // NOTE: memory has no reset; contents survive reset and start undefined.
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.O_wr_ready     = (state_q != CLEAR);
   assign bus.O_swap_pending = (state_q == PENDING);
   assign bus.O_swap_done    = swap_done_q;
   assign bus.O_rd_data      = rd_data_q;
   assign bus.O_rd_valid     = rd_valid_q;
   assign bus.O_front_bank   = front_q;

endmodule

// File: tb/tb_pingpong_framebuffer.sv
// Directed bench for pingpong_framebuffer with a read scoreboard: each read
// pushes its expected data from a small bank model, and the result is popped
// and compared the cycle the DUT presents it.
module tb_pingpong_framebuffer;

   localparam int DW = 8;
   localparam int AW = 4;

   logic I_clk = 1'b0;
   logic I_rst = 1'b1;

   pingpong_framebuffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   pingpong_framebuffer #(
      .DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_SWAP(1'b1), .CLEAR_VALUE(8'h11)
   ) dut (
      .I_clk (I_clk),
      .I_rst (I_rst),
      .bus   (bus)
   );

   always #5 I_clk = ~I_clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // kind: 0 = data unknown (valid only), 1 = must equal val, 2 = must differ from val
   typedef struct {
      int         kind;
      logic [7:0] val;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_mem   [2][16];
   bit         exp_known [2][16];
   int         front_m = 0;
   int         checks  = 0;
   int         errors  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] forbid);
      checks++;
      assert (obs !== forbid) else begin
         errors++;
         $error("FAIL %s @%0t observed=%0h expected anything but %0h", tag, $time, obs, forbid);
      end
   endtask

   // One clock; afterwards check the read scoreboard.
   task automatic step();
      bit   exp_v;
      exp_t e;
      exp_v = (sb.size() != 0);
      @(posedge I_clk);
      #1;
      check("rd_valid", 32'(bus.O_rd_valid), 32'(exp_v));
      if (exp_v) begin
         e = sb.pop_front();
         if (e.kind == 1)      check("rd_data", 32'(bus.O_rd_data), 32'(e.val));
         else if (e.kind == 2) check_ne("rd_data_not_back", 32'(bus.O_rd_data), 32'(e.val));
      end
   endtask

   // Drive one cycle of stimulus; reads push their expectation from the model.
   task automatic cycle(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input bit re, input logic [3:0] ra, input bit sw, input bit fs);
      exp_t e;
      bus.I_wr_en       = we;
      bus.I_wr_addr     = wa;
      bus.I_wr_data     = wd;
      bus.I_rd_en       = re;
      bus.I_rd_addr     = ra;
      bus.I_swap_req    = sw;
      bus.I_frame_start = fs;
      if (re) begin
         if (exp_known[front_m][ra]) begin
            e.kind = 1; e.val = exp_mem[front_m][ra];
         end else if (exp_known[1-front_m][ra]) begin
            e.kind = 2; e.val = exp_mem[1-front_m][ra];
         end else begin
            e.kind = 0; e.val = 8'h00;
         end
         sb.push_back(e);
      end
      step();
      bus.I_wr_en       = 1'b0;
      bus.I_rd_en       = 1'b0;
      bus.I_swap_req    = 1'b0;
      bus.I_frame_start = 1'b0;
   endtask

   task automatic mwrite(input logic [3:0] a, input logic [7:0] d);
      exp_mem[1-front_m][a]   = d;
      exp_known[1-front_m][a] = 1'b1;
   endtask

   task automatic mclear(input int b);
      for (int i = 0; i < 16; i++) begin
         exp_mem[b][i]   = 8'h11;
         exp_known[b][i] = 1'b1;
      end
   endtask

   // Count cycles with O_wr_ready low, starting at the commit sample.
   task automatic wait_clear(input string tag, input bit do_rd, input bit do_wr, input bit do_sw);
      int low;
      low = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.O_wr_ready === 1'b1) break;
         low++;
         cycle(do_wr && i == 2, 4'd5, 8'h77, do_rd && i == 0, 4'd3, do_sw && i == 4, 1'b0);
      end
      check(tag, 32'(low), 32'd16);
   endtask

   initial begin
      bus.I_wr_en = 1'b0; bus.I_wr_addr = '0; bus.I_wr_data = '0;
      bus.I_rd_en = 1'b0; bus.I_rd_addr = '0;
      bus.I_swap_req = 1'b0; bus.I_frame_start = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 16; i++) begin
            exp_mem[b][i] = 8'h00; exp_known[b][i] = 1'b0;
         end

      // Reset state
      I_rst = 1'b1;
      step();
      step();
      check("rst_front",    32'(bus.O_front_bank),   32'd0);
      check("rst_pending",  32'(bus.O_swap_pending), 32'd0);
      check("rst_done",     32'(bus.O_swap_done),    32'd0);
      check("rst_rd_data",  32'(bus.O_rd_data),      32'd0);
      check("rst_wr_ready", 32'(bus.O_wr_ready),     32'd1);
      I_rst = 1'b0;

      // Write goes to back bank 1; a read of the front bank does not see it.
      cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0);
      mwrite(4'd3, 8'hA5);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0);

      // Arm a swap; front stays put until frame start.
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
      check("arm_pending", 32'(bus.O_swap_pending), 32'd1);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0);
      check("arm_front", 32'(bus.O_front_bank), 32'd0);
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
      check("commit1_done",    32'(bus.O_swap_done),    32'd1);
      check("commit1_front",   32'(bus.O_front_bank),   32'd1);
      check("commit1_pending", 32'(bus.O_swap_pending), 32'd0);
      front_m = 1;
      mclear(0);

      // Clear: read during it, a dropped write, an ignored swap request.
      wait_clear("clear1_len", 1'b1, 1'b1, 1'b1);
      check("clear1_sw_ignored", 32'(bus.O_swap_pending), 32'd0);
      check("clear1_done_low",   32'(bus.O_swap_done),    32'd0);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0);

      // Frame start with nothing pending does nothing.
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
      check("idle_fs_front", 32'(bus.O_front_bank), 32'd1);
      check("idle_fs_done",  32'(bus.O_swap_done),  32'd0);

      // Request and frame start together only arm; a repeat request is ignored.
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1);
      check("simul_pending", 32'(bus.O_swap_pending), 32'd1);
      check("simul_front",   32'(bus.O_front_bank),   32'd1);
      check("simul_done",    32'(bus.O_swap_done),    32'd0);
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
      check("rereq_front", 32'(bus.O_front_bank), 32'd1);

      // Commit with a write and a read in the same cycle.
      cycle(1'b1, 4'd7, 8'h3C, 1'b1, 4'd3, 1'b0, 1'b1);
      mwrite(4'd7, 8'h3C);
      front_m = 0;
      check("commit2_done",  32'(bus.O_swap_done),  32'd1);
      check("commit2_front", 32'(bus.O_front_bank), 32'd0);
      mclear(1);
      wait_clear("clear2_len", 1'b0, 1'b0, 1'b0);
      check("clear2_pending", 32'(bus.O_swap_pending), 32'd0);
      check("clear2_front",   32'(bus.O_front_bank),   32'd0);

      // Sweep the new front bank: cleared except the commit-cycle write.
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      check("rd_hold", 32'(bus.O_rd_data), 32'h3C);

      // Reset on the fifth clear cycle.
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
      front_m = 1;
      check("commit3_front", 32'(bus.O_front_bank), 32'd1);
      check("commit3_ready", 32'(bus.O_wr_ready),   32'd0);
      for (int i = 0; i < 4; i++) step();
      I_rst = 1'b1;
      bus.I_rd_en = 1'b1;
      bus.I_rd_addr = 4'd0;
      step();
      I_rst = 1'b0;
      bus.I_rd_en = 1'b0;
      front_m = 0;
      check("midclr_front",   32'(bus.O_front_bank),   32'd0);
      check("midclr_ready",   32'(bus.O_wr_ready),     32'd1);
      check("midclr_pending", 32'(bus.O_swap_pending), 32'd0);
      check("midclr_valid",   32'(bus.O_rd_valid),     32'd0);
      // Bank 0 was only partly cleared; address 7 keeps its data.
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pingpong_framebuffer.md
Name: pingpong_framebuffer

Overview:
- Parametrised double-buffered (ping-pong) pixel memory between the UART control writer and the video scan-out reader.
- Writer always targets the back bank. Video always reads the front bank.
- A swap request is deferred to the next frame boundary, so bank exchange is tear-free.
- Optional clear-on-swap fills the new back bank with a constant before the writer may touch it.

Parameters:
- DATA_W, 8, pixel/data word width in bits.
- ADDR_W, 4, address width; each bank holds 2**ADDR_W words.
- CLEAR_ON_SWAP, 1, 1 = clear new back bank after each swap; 0 = no clear.
- CLEAR_VALUE, 0, word written to every location during clear (DATA_W bits).

Ports:
- I_clk  in  1  single system clock; all logic on rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_wr_en  in  1  write strobe from control side.
- I_wr_addr  in  ADDR_W  write address into back bank.
- I_wr_data  in  DATA_W  write data.
- O_wr_ready  out  1  1 = writes accepted; 0 = writes dropped (clear in progress).
- I_swap_req  in  1  one-cycle pulse requesting bank exchange.
- O_swap_pending  out  1  swap armed, waiting for frame boundary.
- O_swap_done  out  1  one-cycle pulse on the cycle the front bank changes.
- I_frame_start  in  1  one-cycle pulse at start of frame (vertical boundary) from the video timing.
- I_rd_en  in  1  read strobe from video side (pixel enable).
- I_rd_addr  in  ADDR_W  read address into front bank.
- O_rd_data  out  DATA_W  registered read data.
- O_rd_valid  out  1  O_rd_data valid this cycle.
- O_front_bank  out  1  index of bank currently displayed (0/1).

Behaviour:
- Reset (I_rst=1 at a clock edge):
  - state=IDLE, O_front_bank=0, O_swap_pending=0, O_swap_done=0, O_rd_valid=0, O_rd_data=0, O_wr_ready=1, clear counter=0.
  - Memory contents are not reset.
- Back bank is always !O_front_bank.
- Read:
  - I_rd_en=1 at edge N gives O_rd_data = front[I_rd_addr] and O_rd_valid=1 at edge N+1.
  - I_rd_en=0 gives O_rd_valid=0 next cycle; O_rd_data holds its last value.
  - Latency is exactly 1 cycle. Reads are never stalled.
- Write:
  - When I_wr_en=1 and O_wr_ready=1, back[I_wr_addr] <= I_wr_data.
  - When O_wr_ready=0, the write is silently dropped.
- State machine:
  - IDLE: I_swap_req=1 -> PENDING, O_swap_pending=1. Writes accepted.
  - PENDING: writes still go to the current back bank. On I_frame_start=1:
    - toggle O_front_bank and pulse O_swap_done.
    - O_swap_pending=0.
    - go to CLEAR if CLEAR_ON_SWAP=1, else IDLE.
  - CLEAR: O_wr_ready=0. Each cycle writes CLEAR_VALUE to new back[cnt] and increments cnt from 0 to 2**ADDR_W-1. After the last address -> IDLE, O_wr_ready=1, cnt=0. Duration is exactly 2**ADDR_W cycles.
  - I_swap_req in PENDING or CLEAR is ignored and not queued.
- Simultaneous events:
  - I_swap_req and I_frame_start in the same cycle while IDLE: arm only. Swap occurs at the next I_frame_start.
  - Write and swap commit in the same cycle: the write lands in the pre-commit back bank, which becomes the new front.
  - Read and swap commit in the same cycle: the read uses the pre-commit front bank.
  - I_frame_start with no swap pending: no effect.
- Reset mid-CLEAR: returns to IDLE with front=0. Partially cleared bank contents remain.

Test Plan:
- Reset, write addr 3=0xA5 (to bank 1), read addr 3 -> O_rd_data is bank0 content (not 0xA5); O_rd_valid 1 cycle after I_rd_en.
- Write addr 3=0xA5, pulse I_swap_req, read addr 3 before I_frame_start -> old data, O_swap_pending=1. Pulse I_frame_start -> O_swap_done pulse, O_front_bank=1, next read of addr 3 returns 0xA5.
- CLEAR_ON_SWAP=1, ADDR_W=4, CLEAR_VALUE=0x11: after swap, O_wr_ready=0 for exactly 16 cycles. A write issued during clear is dropped. After clear, reads following a second swap return 0x11 at all 16 addresses.
- I_swap_req and I_frame_start in the same cycle -> no swap. Front changes only at the following I_frame_start. A second I_swap_req during PENDING does not cause a double toggle.
- Write 0x3C to addr 7 on the commit cycle -> after commit, front[7]=0x3C. A read issued on the commit cycle returns the old front value.
- Assert I_rst on the 5th CLEAR cycle -> next cycle O_front_bank=0, O_wr_ready=1, O_swap_pending=0, O_rd_valid=0.
